// File: rtl/game2048_pkg.sv
// Shared types for the 2048 game sequencer: FSM state codes, move directions,
// and a helper that flags the states which hold a handshake open.
package game2048_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_INIT  = 4'd1,
        ST_WAIT  = 4'd2,
        ST_MOVE  = 4'd3,
        ST_SPAWN = 4'd4,
        ST_CHECK = 4'd5,
        ST_WIN   = 4'd6,
        ST_LOSE  = 4'd7,
        ST_ERR   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE = 3'd0,
        DIR_IZQ  = 3'd1,
        DIR_DER  = 3'd2,
        DIR_UP   = 3'd3,
        DIR_DOWN = 3'd4
    } dir_t;

    localparam int NUM_DIRS = 4;

    function automatic logic is_busy(input state_t s);
        return (s == ST_INIT) || (s == ST_MOVE) || (s == ST_SPAWN) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/game_seq_ctrl_btn_edge_arb.sv
// Button rising-edge detector with fixed-priority encode (izq > der > up > down).
// Edges are reported every cycle; the sequencer decides whether to act on them.
module btn_edge_arb
    import game2048_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn_izq,
    input  logic btn_der,
    input  logic btn_up,
    input  logic btn_down,
    output logic press,
    output dir_t dir
);

    logic [NUM_DIRS-1:0] btn_d;
    logic [NUM_DIRS-1:0] btn_q;
    logic [NUM_DIRS-1:0] rise;

    always_comb begin
        btn_d = {btn_down, btn_up, btn_der, btn_izq};
    end

    always_ff @(posedge clk) begin
        if (!rst) btn_q <= '0;
        else      btn_q <= btn_d;
    end

    assign rise = btn_d & ~btn_q;

    always_comb begin
        press = |rise;
        dir   = DIR_NONE;
        if      (rise[0]) dir = DIR_IZQ;
        else if (rise[1]) dir = DIR_DER;
        else if (rise[2]) dir = DIR_UP;
        else if (rise[3]) dir = DIR_DOWN;
    end

endmodule

// File: rtl/game_seq_ctrl.sv
// 2048 game sequencer: one move at a time through move -> spawn -> check
// handshakes, with a per-state watchdog and a saturating changed-move counter.
module game_seq_ctrl
    import game2048_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fin,
    input  logic             btn_izq,
    input  logic             btn_der,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             init_done,
    input  logic             move_done,
    input  logic             move_changed,
    input  logic             spawn_done,
    input  logic             check_done,
    input  logic             win,
    input  logic             lose,
    output logic [3:0]       estado,
    output logic [2:0]       mov,
    output logic             init_req,
    output logic             move_start,
    output logic             spawn_req,
    output logic             check_req,
    output logic             busy,
    output logic [CNT_W-1:0] move_count
);

    localparam int               WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    dir_t             mov_q, mov_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [3:0]       req_q, req_d;
    logic             press;
    dir_t             press_dir;
    logic             wd_expired;

    btn_edge_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .btn_izq  (btn_izq),
        .btn_der  (btn_der),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .press    (press),
        .dir      (press_dir)
    );

    always_comb begin
        state_d    = state_q;
        mov_d      = mov_q;
        cnt_d      = cnt_q;
        wd_expired = (wd_q == WD_LAST);

        // fin is checked first everywhere so it overrides any done or timeout
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_INIT;
            ST_INIT: begin
                if      (fin)        state_d = ST_IDLE;
                else if (init_done)  state_d = ST_WAIT;
                else if (wd_expired) state_d = ST_ERR;
            end
            ST_WAIT: begin
                if (fin) state_d = ST_IDLE;
                else if (press) begin
                    state_d = ST_MOVE;
                    mov_d   = press_dir;
                end
            end
            ST_MOVE: begin
                if (fin) state_d = ST_IDLE;
                else if (move_done) begin
                    if (move_changed) begin
                        state_d = ST_SPAWN;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (wd_expired) state_d = ST_ERR;
            end
            ST_SPAWN: begin
                if      (fin)        state_d = ST_IDLE;
                else if (spawn_done) state_d = ST_CHECK;
                else if (wd_expired) state_d = ST_ERR;
            end
            ST_CHECK: begin
                if (fin) state_d = ST_IDLE;
                else if (check_done) begin
                    if      (win)  state_d = ST_WIN;
                    else if (lose) state_d = ST_LOSE;
                    else           state_d = ST_WAIT;
                end else if (wd_expired) state_d = ST_ERR;
            end
            ST_WIN, ST_LOSE, ST_ERR: begin
                if      (fin)   state_d = ST_IDLE;
                else if (start) state_d = ST_INIT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_INIT && state_q != ST_INIT) cnt_d = '0;
        if (state_d == ST_IDLE || state_d == ST_INIT || state_d == ST_WAIT) mov_d = DIR_NONE;

        wd_d = (state_d != state_q || !is_busy(state_q)) ? '0 : wd_q + 1'b1;

        req_d    = '0;
        req_d[0] = (state_d == ST_INIT)  && (state_q != ST_INIT);
        req_d[1] = (state_d == ST_MOVE)  && (state_q != ST_MOVE);
        req_d[2] = (state_d == ST_SPAWN) && (state_q != ST_SPAWN);
        req_d[3] = (state_d == ST_CHECK) && (state_q != ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mov_q   <= DIR_NONE;
            cnt_q   <= '0;
            wd_q    <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            mov_q   <= mov_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            req_q   <= req_d;
        end
    end

    assign estado     = state_q;
    assign mov        = mov_q;
    assign move_count = cnt_q;
    assign init_req   = req_q[0];
    assign move_start = req_q[1];
    assign spawn_req  = req_q[2];
    assign check_req  = req_q[3];
    assign busy       = is_busy(state_q);

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Scoreboard bench for game_seq_ctrl: stimulus queues the expected state entry,
// a monitor pops and compares each time estado changes.
module tb_game_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, fin;
    logic        btn_izq, btn_der, btn_up, btn_down;
    logic        init_done, move_done, move_changed, spawn_done, check_done, win, lose;
    logic [3:0]  estado;
    logic [2:0]  mov;
    logic        init_req, move_start, spawn_req, check_req, busy;
    logic [15:0] move_count;

    always #5 clk = ~clk;

    game_seq_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .fin(fin),
        .btn_izq(btn_izq), .btn_der(btn_der), .btn_up(btn_up), .btn_down(btn_down),
        .init_done(init_done), .move_done(move_done), .move_changed(move_changed),
        .spawn_done(spawn_done), .check_done(check_done), .win(win), .lose(lose),
        .estado(estado), .mov(mov), .init_req(init_req), .move_start(move_start),
        .spawn_req(spawn_req), .check_req(check_req), .busy(busy), .move_count(move_count)
    );

    typedef struct {
        logic [3:0]  est;
        logic [2:0]  mv;
        logic [15:0] cnt;
        logic [3:0]  req;
        logic        bz;
        int          dwell;   // cycles spent in the previous state, 0 = don't care
    } exp_t;

    localparam logic [3:0] R_NO = 4'b0000, R_I = 4'b0001, R_M = 4'b0010, R_S = 4'b0100, R_C = 4'b1000;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic expect_st(input logic [3:0] est, input logic [2:0] mv, input logic [15:0] cnt,
                             input logic [3:0] req, input logic bz, input int dwell);
        exp_t e;
        e.est = est; e.mv = mv; e.cnt = cnt; e.req = req; e.bz = bz; e.dwell = dwell;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    initial begin : monitor
        logic [3:0] prev;
        logic [3:0] reqv;
        int         dwell;
        exp_t       e;
        prev  = 4'hF;
        dwell = 0;
        forever begin
            @(negedge clk);
            reqv = {check_req, spawn_req, move_start, init_req};
            if (estado !== prev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_state got %0d want %0d", estado, prev);
                end else begin
                    e = q.pop_front();
                    chk("estado", estado, e.est);
                    chk("mov", mov, e.mv);
                    chk("move_count", move_count, e.cnt);
                    chk("req_pulse", reqv, e.req);
                    chk("busy", busy, e.bz);
                    if (e.dwell != 0) chk("dwell", dwell, e.dwell);
                end
                prev  = estado;
                dwell = 1;
            end else begin
                dwell++;
                chk("no_pulse", reqv, R_NO);
            end
        end
    end

    task automatic start_game();
        expect_st(4'd1, 3'd0, 16'd0, R_I, 1'b1, 0);
        start = 1; tick(); start = 0;
        expect_st(4'd2, 3'd0, 16'd0, R_NO, 1'b0, 0);
        init_done = 1; tick(); init_done = 0;
    endtask

    initial begin
        rst = 0; start = 0; fin = 0;
        btn_izq = 0; btn_der = 0; btn_up = 0; btn_down = 0;
        init_done = 0; move_done = 0; move_changed = 0;
        spawn_done = 0; check_done = 0; win = 0; lose = 0;

        expect_st(4'd0, 3'd0, 16'd0, R_NO, 1'b0, 0);
        repeat (3) tick();
        rst = 1;
        tick();

        // start, init_done in the 5th INIT cycle
        expect_st(4'd1, 3'd0, 16'd0, R_I, 1'b1, 0);
        start = 1; tick(); start = 0;
        repeat (4) tick();
        expect_st(4'd2, 3'd0, 16'd0, R_NO, 1'b0, 5);
        init_done = 1; tick(); init_done = 0;
        spawn_done = 1; tick(); spawn_done = 0;     // stray done in WAIT

        // up move through full cycle; der edge during MOVE ignored
        expect_st(4'd3, 3'd3, 16'd0, R_M, 1'b1, 0);
        btn_up = 1; tick();
        btn_der = 1; tick();
        expect_st(4'd4, 3'd3, 16'd1, R_S, 1'b1, 2);
        move_done = 1; move_changed = 1; tick(); move_done = 0; move_changed = 0;
        expect_st(4'd5, 3'd3, 16'd1, R_C, 1'b1, 1);
        spawn_done = 1; tick(); spawn_done = 0;
        expect_st(4'd2, 3'd0, 16'd1, R_NO, 1'b0, 1);
        check_done = 1; tick(); check_done = 0;
        btn_up = 0; btn_der = 0; tick();

        // izq beats down; unchanged move returns to WAIT
        expect_st(4'd3, 3'd1, 16'd1, R_M, 1'b1, 0);
        btn_izq = 1; btn_down = 1; tick(); btn_izq = 0; btn_down = 0;
        expect_st(4'd2, 3'd0, 16'd1, R_NO, 1'b0, 1);
        move_done = 1; tick(); move_done = 0;
        tick();

        // win beats lose, then restart clears count
        expect_st(4'd3, 3'd2, 16'd1, R_M, 1'b1, 0);
        btn_der = 1; tick(); btn_der = 0;
        expect_st(4'd4, 3'd2, 16'd2, R_S, 1'b1, 0);
        move_done = 1; move_changed = 1; tick(); move_done = 0; move_changed = 0;
        expect_st(4'd5, 3'd2, 16'd2, R_C, 1'b1, 0);
        spawn_done = 1; tick(); spawn_done = 0;
        expect_st(4'd6, 3'd2, 16'd2, R_NO, 1'b0, 0);
        check_done = 1; win = 1; lose = 1; tick(); check_done = 0; win = 0; lose = 0;
        tick();
        start_game();

        // lose path, then start&fin together -> IDLE
        expect_st(4'd3, 3'd4, 16'd0, R_M, 1'b1, 0);
        btn_down = 1; tick(); btn_down = 0;
        expect_st(4'd4, 3'd4, 16'd1, R_S, 1'b1, 0);
        move_done = 1; move_changed = 1; tick(); move_done = 0; move_changed = 0;
        expect_st(4'd5, 3'd4, 16'd1, R_C, 1'b1, 0);
        spawn_done = 1; tick(); spawn_done = 0;
        expect_st(4'd7, 3'd4, 16'd1, R_NO, 1'b0, 0);
        check_done = 1; lose = 1; tick(); check_done = 0; lose = 0;
        tick();
        expect_st(4'd0, 3'd0, 16'd1, R_NO, 1'b0, 0);
        start = 1; fin = 1; tick(); start = 0; fin = 0;
        tick();

        // fin beats move_done
        start_game();
        expect_st(4'd3, 3'd1, 16'd0, R_M, 1'b1, 0);
        btn_izq = 1; tick(); btn_izq = 0;
        expect_st(4'd0, 3'd0, 16'd0, R_NO, 1'b0, 0);
        move_done = 1; move_changed = 1; fin = 1; tick();
        move_done = 0; move_changed = 0; fin = 0;

        // done on the last watchdog cycle still wins
        start_game();
        expect_st(4'd3, 3'd3, 16'd0, R_M, 1'b1, 0);
        btn_up = 1; tick(); btn_up = 0;
        repeat (7) tick();
        expect_st(4'd4, 3'd3, 16'd1, R_S, 1'b1, 8);
        move_done = 1; move_changed = 1; tick(); move_done = 0; move_changed = 0;
        expect_st(4'd5, 3'd3, 16'd1, R_C, 1'b1, 1);
        spawn_done = 1; tick(); spawn_done = 0;
        expect_st(4'd2, 3'd0, 16'd1, R_NO, 1'b0, 1);
        check_done = 1; tick(); check_done = 0;

        // reset mid-MOVE overrides an arriving move_done
        expect_st(4'd3, 3'd2, 16'd1, R_M, 1'b1, 0);
        btn_der = 1; tick(); btn_der = 0;
        tick();
        expect_st(4'd0, 3'd0, 16'd0, R_NO, 1'b0, 0);
        rst = 0; move_done = 1; move_changed = 1;
        repeat (3) tick();
        rst = 1; move_done = 0; move_changed = 0;
        repeat (2) tick();

        // watchdog expiry in MOVE, then fin from ERR
        start_game();
        expect_st(4'd3, 3'd3, 16'd0, R_M, 1'b1, 0);
        btn_up = 1; tick(); btn_up = 0;
        expect_st(4'd8, 3'd3, 16'd0, R_NO, 1'b0, 8);
        drain(30);
        expect_st(4'd0, 3'd0, 16'd0, R_NO, 1'b0, 0);
        fin = 1; tick(); fin = 0;
        drain(20);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
